// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and password constants for the lock and PasswordSet.
package lock_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, OPEN, SET_WAIT, COMMIT, ALARM} lock_state_t;
  localparam int PW_W_DEFAULT = 6;
  localparam logic [PW_W_DEFAULT-1:0] DEFAULT_PW = '0;
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter; expired is high while the count sits at zero.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/lock_controller.sv
// lock_controller: password check, change sequencing and alarm lockout FSM.
// Optional LOCK_AUTORELOCK_EN relocks OPEN after OPEN_CYCLES idle cycles.
module lock_controller
  import lock_pkg::*;
#(
  parameter int PW_W        = lock_pkg::PW_W_DEFAULT,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int OPEN_CYCLES = 32,
  localparam int EW = $clog2(MAX_TRIES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PW_W-1:0] pw_in,
  input  logic            enter,
  input  logic            set_req,
  input  logic [PW_W-1:0] npw_i,
  output logic [PW_W-1:0] pw_o,
  output logic            set_o,
  output logic            unlocked,
  output logic            alarm,
  output logic [EW-1:0]   err_cnt
);
  localparam int TMAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  lock_state_t state_q, state_d;
  logic [PW_W-1:0] code_q, code_d, pw_q, pw_d;
  logic [EW-1:0] err_q, err_d;
  logic tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      pw_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pw_q    <= pw_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pw_d    = pw_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (enter) begin
        code_d  = pw_in;
        state_d = CHECK;
      end
      CHECK: if (code_q == npw_i) begin
        err_d   = '0;
        state_d = OPEN;
      end else begin
        err_d   = (err_q == EW'(MAX_TRIES)) ? err_q : err_q + 1'b1;
        state_d = (err_d == EW'(MAX_TRIES)) ? ALARM : IDLE;
      end
`ifdef LOCK_AUTORELOCK_EN
      OPEN: state_d = set_req ? SET_WAIT : (enter || tmr_exp) ? IDLE : OPEN;
`else
      OPEN: state_d = set_req ? SET_WAIT : enter ? IDLE : OPEN;
`endif
      SET_WAIT: if (set_req) state_d = OPEN;
      else if (enter) begin
        pw_d    = pw_in;
        state_d = COMMIT;
      end
      COMMIT: state_d = OPEN;
      ALARM: if (tmr_exp) begin
        err_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Counts are loaded with N-1 so the state is held for exactly N cycles.
  always_comb begin
`ifdef LOCK_AUTORELOCK_EN
    tmr_load = (state_d == ALARM && state_q != ALARM) ||
               (state_d == OPEN && (state_q != OPEN || enter || set_req));
`else
    tmr_load = state_d == ALARM && state_q != ALARM;
`endif
    tmr_val = (state_d == ALARM) ? TW'(LOCK_CYCLES - 1) : TW'(OPEN_CYCLES - 1);
  end
  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );
  always_comb begin
    set_o    = state_q == COMMIT;
    unlocked = state_q inside {OPEN, SET_WAIT, COMMIT};
    alarm    = state_q == ALARM;
    pw_o     = pw_q;
    err_cnt  = err_q;
  end
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed checks of unlock, lockout, password change, cancel and reset.
module tb_lock_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] pw_in = '0;
  logic       enter = 1'b0;
  logic       set_req = 1'b0;
  logic [5:0] npw_i = '0;
  logic [5:0] pw_o;
  logic       set_o, unlocked, alarm;
  logic [1:0] err_cnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  lock_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pw_in    (pw_in),
    .enter    (enter),
    .set_req  (set_req),
    .npw_i    (npw_i),
    .pw_o     (pw_o),
    .set_o    (set_o),
    .unlocked (unlocked),
    .alarm    (alarm),
    .err_cnt  (err_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press(input logic [5:0] code, input logic e, input logic s);
    pw_in   = code;
    enter   = e;
    set_req = s;
    @(negedge clk);
    enter   = 1'b0;
    set_req = 1'b0;
  endtask
  task automatic unlock(input logic [5:0] code);
    press(code, 1'b1, 1'b0);
    @(negedge clk);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_unlocked", unlocked, 0);
    check("rst_alarm", alarm, 0);
    check("rst_set", set_o, 0);
    check("rst_pw", pw_o, 0);
    check("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    press(6'd0, 1'b1, 1'b0);
    check("check_cycle_locked", unlocked, 0);
    @(negedge clk);
    check("good_unlocked", unlocked, 1);
    check("good_err", err_cnt, 0);
    press(6'd0, 1'b1, 1'b0);
    check("relock", unlocked, 0);
    for (int i = 1; i <= 3; i++) begin
      unlock(6'd5);
      if (i < 3) check($sformatf("fail_err%0d", i), err_cnt, i);
    end
    check("alarm_on", alarm, 1);
    n = 0;
    while (alarm && n < 100) begin
      enter = (n == 3);
      n++;
      @(negedge clk);
    end
    enter = 1'b0;
    check("alarm_len", n, 16);
    check("post_alarm_err", err_cnt, 0);
    check("post_alarm_locked", unlocked, 0);
    @(negedge clk);
    check("alarm_enter_ignored", unlocked, 0);
    unlock(6'd0);
    check("reopen", unlocked, 1);
    press(6'd0, 1'b0, 1'b1);
    check("set_wait_unlocked", unlocked, 1);
    check("set_wait_no_strobe", set_o, 0);
    press(6'd42, 1'b1, 1'b0);
    check("commit_strobe", set_o, 1);
    check("commit_pw", pw_o, 42);
    npw_i = 6'd42;
    @(negedge clk);
    check("strobe_one_cycle", set_o, 0);
    check("back_open", unlocked, 1);
    press(6'd0, 1'b1, 1'b0);
    unlock(6'd0);
    check("old_pw_rejected", unlocked, 0);
    check("old_pw_err", err_cnt, 1);
    unlock(6'd42);
    check("new_pw_unlocked", unlocked, 1);
    check("new_pw_err", err_cnt, 0);
    press(6'd0, 1'b0, 1'b1);
    press(6'd7, 1'b1, 1'b1);
    check("cancel_no_strobe", set_o, 0);
    check("cancel_open", unlocked, 1);
    @(negedge clk);
    check("cancel_no_strobe2", set_o, 0);
    check("cancel_pw_kept", pw_o, 42);
    press(6'd0, 1'b1, 1'b1);
    check("prio_unlocked", unlocked, 1);
    press(6'd9, 1'b1, 1'b0);
    check("prio_set_wait_strobe", set_o, 1);
    check("prio_pw", pw_o, 9);
    @(negedge clk);
    press(6'd0, 1'b0, 1'b1);
    press(6'd11, 1'b1, 1'b0);
    check("commit2_strobe", set_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst_commit_set", set_o, 0);
    check("rst_commit_unlocked", unlocked, 0);
    check("rst_commit_pw", pw_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_rst_set", set_o, 0);
    check("after_rst_unlocked", unlocked, 0);
    for (int i = 0; i < 3; i++) unlock(6'd5);
    check("alarm2_on", alarm, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_alarm_alarm", alarm, 0);
    check("rst_alarm_err", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    unlock(6'd42);
    check("after_alarm_rst_unlock", unlocked, 1);
`ifdef LOCK_AUTORELOCK_EN
    n = 0;
    while (unlocked && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("autorelock_len", n, 32);
    unlock(6'd42);
    repeat (20) @(negedge clk);
    press(6'd0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    check("set_wait_no_timeout", unlocked, 1);
    press(6'd0, 1'b0, 1'b1);
    n = 1;
    while (unlocked && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("autorelock_restart_len", n, 33);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing FSM for the 6-bit password lock: samples entered codes, compares them against the stored password held by the `PasswordSet` register, and drives the set strobe and new-password value to change that password. Also counts failed attempts and enforces a timed alarm lockout. Sits between the user-input debounce/pulse logic and `PasswordSet`, and drives the unlock and alarm indicators.

## Interface
- `PW_W`, 6, password width in bits
- `MAX_TRIES`, 3, consecutive failures that trigger ALARM (≥1)
- `LOCK_CYCLES`, 16, ALARM duration in clock cycles (≥1)
- `OPEN_CYCLES`, 32, auto-relock timeout (used only with `LOCK_AUTORELOCK_EN`)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pw_in`  in  PW_W  entered code, valid when `enter`=1
- `enter`  in  1  one-cycle pulse: submit `pw_in`
- `set_req`  in  1  one-cycle pulse: request/cancel password change
- `npw_i`  in  PW_W  stored password from `PasswordSet`
- `pw_o`  out  PW_W  new password to `PasswordSet`
- `set_o`  out  1  one-cycle write strobe to `PasswordSet`
- `unlocked`  out  1  high while in OPEN, SET_WAIT or COMMIT
- `alarm`  out  1  high while in ALARM
- `err_cnt`  out  $clog2(MAX_TRIES+1)  consecutive failure count

## Operation
- States: IDLE, CHECK, OPEN, SET_WAIT, COMMIT, ALARM.
- IDLE:
  - `enter` latches `pw_in` into `code_q` and moves to CHECK.
  - `set_req` is ignored.
- CHECK, single cycle:
  - `code_q == npw_i` → OPEN and `err_cnt` := 0.
  - Otherwise `err_cnt` += 1. If the new value equals MAX_TRIES → ALARM; else → IDLE.
- OPEN:
  - `set_req` → SET_WAIT.
  - `enter` alone → IDLE (manual relock).
  - `set_req` has priority when both are high.
- SET_WAIT:
  - `enter` latches `pw_in` into `pw_o` and moves to COMMIT.
  - `set_req` cancels the change → OPEN, `pw_o` unchanged.
  - Simultaneous `enter` and `set_req` → cancel.
- COMMIT, single cycle: `set_o`=1, `pw_o` stable, then → OPEN.
- ALARM:
  - Loads `LOCK_CYCLES` into the timer. All inputs are ignored.
  - On expiry, `err_cnt` := 0 → IDLE.
- `pw_o` holds its last committed value between changes.
- `err_cnt` saturates at MAX_TRIES and never wraps.
- `npw_i` is sampled only in CHECK, so the stored password changes from COMMIT are seen on the next attempt.
- Reset, at any time including mid-ALARM or mid-COMMIT:
  - State → IDLE; `err_cnt`, `pw_o`, `code_q` and the timer → 0.
  - `set_o`, `unlocked` and `alarm` → 0 immediately (asynchronous).
  - A partially issued strobe is not reissued after reset.

## Timing
- All outputs are registered or Moore-decoded from the state register; no combinational path from input to output.
- `enter` sampled at edge k in IDLE:
  - CHECK after edge k.
  - OPEN (`unlocked`=1) or IDLE/ALARM after edge k+1.
  - The unlock result is visible two edges after `enter`.
- `enter` at edge k in SET_WAIT:
  - `set_o`=1 for exactly the cycle after edge k.
  - Back in OPEN after edge k+1.
- `alarm` stays high for exactly LOCK_CYCLES cycles, then IDLE.
- `enter` pulses arriving while in CHECK or COMMIT are dropped.

## Configuration
- `LOCK_AUTORELOCK_EN` defined:
  - In OPEN, the timer loads OPEN_CYCLES on entry and reloads on any `enter` or `set_req`.
  - On expiry → IDLE.
  - SET_WAIT never times out.
- Not defined: OPEN persists until an explicit `enter`; `OPEN_CYCLES` is unused.

## Structure
- Shared package `lock_pkg` holds:
  - the state enum `lock_state_t`;
  - the `PW_W` default constant;
  - the `DEFAULT_PW` constant, which `PasswordSet` also uses.
- One sub-module, `lock_timer`: a loadable down-counter with `load`, `load_val`, `expired` and width `$clog2(max(LOCK_CYCLES, OPEN_CYCLES)+1)`.
- This single timer is shared by ALARM and the auto-relock timeout.

## Test plan
- Correct code: reset, `npw_i`=6'd0, `enter` with `pw_in`=6'd0 → `unlocked`=1 two edges later, `err_cnt`=0.
- Lockout: three `enter` with `pw_in`=6'd5 against `npw_i`=6'd0 → `err_cnt` 1, 2, then `alarm`=1 for exactly 16 cycles. An `enter` during the alarm is ignored. Afterwards IDLE with `err_cnt`=0.
- Password change: in OPEN, `set_req`, then `enter` with `pw_in`=6'd42 → one-cycle `set_o` with `pw_o`=42. With the bench model updating `npw_i`=42, relock, then `enter` 42 → `unlocked`.
- Change cancel and priority: in SET_WAIT, `enter`+`set_req` together → OPEN, no `set_o`, `pw_o` unchanged. In OPEN, `enter`+`set_req` together → SET_WAIT.
- Reset mid-operation: assert `rst_n`=0 mid-ALARM and again in the COMMIT cycle → all outputs 0 immediately, IDLE after release.
- With `LOCK_AUTORELOCK_EN` and OPEN_CYCLES=32: unlock, no input → `unlocked` falls after 32 cycles. A `set_req` at cycle 20 restarts the count.
